// File: rtl/dmem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_map_pkg
//  Purpose  : Shared address map and TX status layout for the data-memory
//             responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_map_pkg;

  // Memory-mapped peripheral word addresses (all reachable as addi r0, -N)
  localparam logic [31:0] ADDR_CYCLE     = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_TX_DATA   = 32'hFFFF_FFF1;
  localparam logic [31:0] ADDR_TX_STATUS = 32'hFFFF_FFF2;
  localparam logic [31:0] ADDR_LED       = 32'hFFFF_FFF3;

  // TX_STATUS bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  // Assemble the TX_STATUS read word; unused bits read as zero
  function automatic logic [31:0] tx_status_word(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic [7:0] count
  );
    logic [31:0] w;
    w                       = '0;
    w[ST_EMPTY]             = empty;
    w[ST_FULL]              = full;
    w[ST_OVF]               = ovf;
    w[ST_COUNT_LSB +: 8]    = count;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fifo
//  Purpose  : Byte transmit FIFO, circular buffer, registered head (no
//             fall-through), valid/ready egress, overflow pulse on dropped push.
//  Revision : 1.0  initial release
// ============================================================================
module tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_ready,
  output logic [7:0]    head,
  output logic          valid,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow_pulse
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push_ok;

  assign valid = (r_count != '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign head  = valid ? r_mem[r_rd_ptr] : 8'h00;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
  assign w_pop          = valid && pop_ready;
  assign w_push_ok      = push && (!full || w_pop);
  assign overflow_pulse = push && full && !w_pop;

  // Storage write; contents are don't-care until a slot is counted as valid
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory port responder. Decodes each M-stage access and
//             steers it to the data RAM or to the MMIO peripherals (cycle
//             counter, TX FIFO, LED). Load data returns combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int TX_DEPTH = 4,
  parameter int LED_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q_dmem,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [LED_W-1:0]  led
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]      r_cycle;
  logic             r_ovf;
  logic [LED_W-1:0] r_led;

  logic          w_is_ram;
  logic          w_sel_cycle;
  logic          w_sel_txd;
  logic          w_sel_stat;
  logic          w_sel_led;
  logic          w_fifo_full;
  logic [CW-1:0] w_fifo_count;
  logic          w_ovf_pulse;
  logic [31:0]   w_status;

  // Address decode: RAM region is every address whose upper bits are zero
  assign w_is_ram    = (address_dmem >> RAM_AW) == 32'd0;
  assign w_sel_cycle = (address_dmem == ADDR_CYCLE);
  assign w_sel_txd   = (address_dmem == ADDR_TX_DATA);
  assign w_sel_stat  = (address_dmem == ADDR_TX_STATUS);
  assign w_sel_led   = (address_dmem == ADDR_LED);

  // RAM address/data always driven; only the enable is gated by decode
  assign ram_addr  = address_dmem[RAM_AW-1:0];
  assign ram_wdata = data;
  assign ram_wren  = wren && w_is_ram;

  assign led = r_led;

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (wren && w_sel_txd),
    .push_data      (data[7:0]),
    .pop_ready      (tx_ready),
    .head           (tx_data),
    .valid          (tx_valid),
    .full           (w_fifo_full),
    .count          (w_fifo_count),
    .overflow_pulse (w_ovf_pulse)
  );

  assign w_status = tx_status_word(!tx_valid, w_fifo_full, r_ovf, 8'(w_fifo_count));

  // Free-running cycle counter; a store overrides the increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else if (wren && w_sel_cycle) begin
      r_cycle <= data;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Sticky overflow: set by a dropped push, cleared by any TX_STATUS store.
  // Both cannot happen together since the single port carries one access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (wren && w_sel_stat) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_pulse) begin
      r_ovf <= 1'b1;
    end
  end

  // LED register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
    end else if (wren && w_sel_led) begin
      r_led <= data[LED_W-1:0];
    end
  end

  // Side-effect-free load mux; unmapped addresses and TX_DATA read zero
  always_comb begin
    q_dmem = 32'd0;
    if (w_is_ram) begin
      q_dmem = ram_q;
    end else if (w_sel_cycle) begin
      q_dmem = r_cycle;
    end else if (w_sel_stat) begin
      q_dmem = w_status;
    end else if (w_sel_led) begin
      q_dmem = 32'(r_led);
    end
  end

endmodule
`default_nettype wire
